// File: rtl/approx_mult_iter.sv
// Iterative truncation-based approximate unsigned multiplier: retires RADIX_BITS
// multiplier bits per cycle, masking the low tc columns of every partial product.
module approx_mult_iter #(
  parameter int WIDTH      = 16,
  parameter int RADIX_BITS = 2,
  parameter int TW         = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [TW-1:0]        trunc,
  input  logic                 comp_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy
);

  localparam int STEPS = (RADIX_BITS > 0) ? WIDTH / RADIX_BITS : 1;
  localparam int PW    = 2 * WIDTH;
  localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (RADIX_BITS < 1) begin : g_bad_radix
    $error("approx_mult_iter: RADIX_BITS must be at least 1");
  end else if (WIDTH % RADIX_BITS != 0) begin : g_bad_width
    $error("approx_mult_iter: WIDTH must be divisible by RADIX_BITS");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [TW-1:0]       tc_q;
  logic                comp_q;
  logic [SW-1:0]       step_q;
  logic [PW-1:0]       acc_q;
  logic [PW-1:0]       result_q;

  logic [TW-1:0]       tc_in;
  logic [31:0]         shamt;
  logic [RADIX_BITS-1:0] digit;
  logic [PW-1:0]       prod;
  logic [PW-1:0]       pp_m;
  logic [PW-1:0]       acc_d;
  logic [PW-1:0]       comp_term;
  logic                last_step;

  assign tc_in = (trunc > TW'(WIDTH)) ? TW'(WIDTH) : trunc;

  // Partial product for the current digit, low tc columns forced to zero
  always_comb begin
    shamt     = 32'(step_q) * 32'(RADIX_BITS);
    digit     = b_q[shamt +: RADIX_BITS];
    prod      = PW'(a_q) * PW'(digit);
    pp_m      = (prod << shamt) & ({PW{1'b1}} << tc_q);
    acc_d     = acc_q + pp_m;
    comp_term = (comp_q && (tc_q != '0)) ? (PW'(1) << (tc_q - TW'(1))) : '0;
    last_step = (step_q == SW'(STEPS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      tc_q        <= '0;
      comp_q      <= 1'b0;
      step_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            tc_q       <= tc_in;
            comp_q     <= comp_en;
            acc_q      <= '0;
            step_q     <= '0;
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          if (last_step) begin
            state_q     <= DONE;
            result_q    <= acc_d + comp_term;
            out_valid_q <= 1'b1;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = result_q;

endmodule

// File: tb/tb_approx_mult_iter.sv
// Bench for approx_mult_iter: directed vector table, handshake/reset sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_approx_mult_iter;

  localparam int W     = 16;
  localparam int RB    = 2;
  localparam int STEPS = W / RB;
  localparam int TW    = $clog2(W + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [TW-1:0]   trunc;
  logic            comp_en;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  result;
  logic            busy;

  int n_cmp  = 0;
  int n_fail = 0;

  approx_mult_iter #(.WIDTH(W), .RADIX_BITS(RB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .trunc     (trunc),
    .comp_en   (comp_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    int             tr;
    bit             c;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: sum of per-digit partial products, each with its low tc bits cleared
  function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input int tr, input bit c);
    longint acc = 0;
    int tc = (tr > W) ? W : tr;
    for (int i = 0; i < STEPS; i++) begin
      longint d  = (longint'(mb) >> (i * RB)) & ((longint'(1) << RB) - 1);
      longint pp = (longint'(ma) * d) << (i * RB);
      pp = (pp >> tc) << tc;
      acc += pp;
    end
    if (c && tc > 0) acc += longint'(1) << (tc - 1);
    return acc[2*W-1:0];
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one operation; returns with out_valid observed (or timed out) at a negedge.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input int itr,
                        input bit ic, input bit ack,
                        output logic [2*W-1:0] res, output int edges);
    int n;
    @(negedge clk);
    a = ia; b = ib; trunc = TW'(itr); comp_en = ic;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); trunc = TW'($urandom); comp_en = 1'($urandom);
    edges = 1;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("done_valid", 64'(out_valid), 64'(1));
    res = result;
    if (ack) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  logic [2*W-1:0] res;
  logic [2*W-1:0] hold;
  int             edges;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; trunc = '0; comp_en = 1'b0;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 0,  1'b0, 32'hFFFE0001};
    vecs[1] = '{16'h00FF, 16'h00FF, 8,  1'b0, 32'h0000FB00};
    vecs[2] = '{16'h00FF, 16'h00FF, 8,  1'b1, 32'h0000FB80};
    vecs[3] = '{16'h1234, 16'h0001, 20, 1'b0, 32'h00000000};
    vecs[4] = '{16'h1234, 16'h0001, 20, 1'b1, 32'h00008000};
    vecs[5] = '{16'hABCD, 16'h0000, 4,  1'b1, 32'h00000008};
    vecs[6] = '{16'hABCD, 16'h0000, 0,  1'b0, 32'h00000000};
    vecs[7] = '{16'h0003, 16'h0005, 0,  1'b0, 32'h0000000F};

    do_reset();
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy",      64'(busy),      64'(0));
    check("rst_result",    64'(result),    64'(0));

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].tr, vecs[i].c, 1'b1, res, edges);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      if (i == 0) check("latency_edges", 64'(edges), 64'(STEPS + 1));
      check($sformatf("vec%0d_release", i), 64'({out_valid, in_ready, busy}), 64'(3'b010));
    end

    // Backpressure: result held, new request ignored until the result is taken
    run_op(16'h1357, 16'h2468, 3, 1'b1, 1'b0, hold, edges);
    check("bp_first", 64'(hold), 64'(model(16'h1357, 16'h2468, 3, 1'b1)));
    a = 16'hBEEF; b = 16'hCAFE; trunc = TW'(5); comp_en = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("bp_valid%0d", k),  64'(out_valid), 64'(1));
      check($sformatf("bp_ready%0d", k),  64'(in_ready),  64'(0));
      check($sformatf("bp_result%0d", k), 64'(result),    64'(hold));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid",  64'(out_valid), 64'(0));
    check("bp_release_ready",  64'(in_ready),  64'(1));
    check("bp_release_result", 64'(result),    64'(hold));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_busy",  64'(busy),     64'(1));
    check("bp_accept_ready", 64'(in_ready), 64'(0));
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("bp_second_edges",  64'(edges),  64'(STEPS));
    check("bp_second_result", 64'(result), 64'(model(16'hBEEF, 16'hCAFE, 5, 1'b0)));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset landing on iteration 3 discards the operation
    a = 16'hFFFF; b = 16'hFFFF; trunc = '0; comp_en = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ready",  64'(in_ready),  64'(1));
    check("mid_rst_valid",  64'(out_valid), 64'(0));
    check("mid_rst_busy",   64'(busy),      64'(0));
    check("mid_rst_result", 64'(result),    64'(0));
    run_op(16'd3, 16'd5, 0, 1'b0, 1'b1, res, edges);
    check("post_rst_result", 64'(res), 64'(15));

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      int rt;
      bit rc;
      ra = (i % 8 == 0) ? 16'hFFFF : W'($urandom);
      rb = (i % 8 == 1) ? 16'hFFFF : W'($urandom);
      rt = $urandom_range(0, 20);
      rc = 1'($urandom);
      run_op(ra, rb, rt, rc, 1'b1, res, edges);
      check($sformatf("rand%0d a=%0h b=%0h t=%0d c=%0d", i, ra, rb, rt, rc),
            64'(res), 64'(model(ra, rb, rt, rc)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
